// File: rtl/sb_config_loader.sv
// Streams single configuration bits into switch-block memories: one word per
// 4 cycles (accept, setup, strobe, hold). Optional macro SB_CFG_ADDR_CHECK_EN rejects decoder field 4'b1111.
module sb_config_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_WORDS  = 54
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [0:ADDR_WIDTH-1] cfg_addr,
  input  logic                  cfg_data,
  output logic [0:0]            enable,
  output logic [0:ADDR_WIDTH-1] address,
  output logic [0:0]            data_in,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [7:0]            wr_count
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [0:ADDR_WIDTH-1]   addr_q, addr_d;
  logic                    data_q, data_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    rej_q, rej_d;
  logic                    armed_q, armed_d;
  logic                    accept;
  logic                    illegal;

`ifdef SB_CFG_ADDR_CHECK_EN
  // Decoder field all-ones selects no decoder output.
  assign illegal = (cfg_addr[3:6] == 4'b1111);
`else
  assign illegal = 1'b0;
`endif

  // armed_q keeps ready low until the first edge after reset release;
  // rej_q gives a rejected word a one-cycle turnaround.
  assign cfg_ready = armed_q && !rej_q && !done_q && (state_q == IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign enable[0] = (state_q == STROBE);
  assign address   = addr_q;
  assign data_in[0] = data_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign wr_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    rej_d   = 1'b0;
    armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
            rej_d = 1'b1;
          end else begin
            addr_d  = cfg_addr;
            data_d  = cfg_data;
            state_d = SETUP;
          end
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        state_d = HOLD;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if ({24'd0, cnt_d} == 32'(NUM_WORDS)) done_d = 1'b1;
      end
      HOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= 1'b0;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rej_q   <= rej_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_sb_config_loader.sv
// Randomized bench for sb_config_loader against a cycle-timeline reference model.
module tb_sb_config_loader;
  localparam int AW = 7;
  localparam int NW = 54;

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [0:AW-1] cfg_addr = '0;
  logic          cfg_data = 1'b0;
  logic [0:0]    enable;
  logic [0:AW-1] address;
  logic [0:0]    data_in;
  logic          cfg_done;
  logic          cfg_err;
  logic [7:0]    wr_count;

  sb_config_loader #(.ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .enable(enable), .address(address),
    .data_in(data_in), .cfg_done(cfg_done), .cfg_err(cfg_err), .wr_count(wr_count)
  );

  always #5 prog_clk = ~prog_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: timeline of events scheduled from each acceptance.
  int m_cnt, m_addr, m_data, m_done, m_err;
  int en_cyc, inc_cyc, rdy_cyc;
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    return (m_done == 0) && (cyc >= rdy_cyc);
  endfunction

  function automatic bit is_illegal(input int a);
`ifdef SB_CFG_ADDR_CHECK_EN
    return (a & 'hF) == 'hF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    chk("enable",   32'(enable),   32'(cyc == en_cyc));
    chk("ready",    32'(cfg_ready), 32'(exp_ready()));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    chk("done",     32'(cfg_done), 32'(m_done));
    chk("err",      32'(cfg_err),  32'(m_err));
    chk("address",  32'(address),  32'(m_addr));
    chk("data_in",  32'(data_in),  32'(m_data));
  endtask

  // Called mid-cycle; reset is asserted and released between two edges.
  task automatic do_reset();
    cfg_valid = 1'b0;
    pReset = 1'b1;
    #1;
    chk("rst_enable", 32'(enable),   32'd0);
    chk("rst_ready",  32'(cfg_ready), 32'd0);
    chk("rst_count",  32'(wr_count), 32'd0);
    chk("rst_done",   32'(cfg_done), 32'd0);
    chk("rst_err",    32'(cfg_err),  32'd0);
    chk("rst_addr",   32'(address),  32'd0);
    chk("rst_data",   32'(data_in),  32'd0);
    m_cnt = 0; m_addr = 0; m_data = 0; m_done = 0; m_err = 0;
    en_cyc = -1; inc_cyc = -1; rdy_cyc = cyc + 1;
    #2;
    pReset = 1'b0;
  endtask

  task automatic step(input bit v, input int a, input bit d);
    cfg_valid = v;
    cfg_addr  = 7'(a);
    cfg_data  = d;
    last_acc  = v && exp_ready();
    if (last_acc) begin
      if (is_illegal(a)) begin
        m_err   = 1;
        rdy_cyc = cyc + 2;
      end else begin
        m_addr  = a & 'h7F;
        m_data  = d;
        en_cyc  = cyc + 2;
        inc_cyc = cyc + 3;
        rdy_cyc = cyc + 4;
      end
    end
    @(posedge prog_clk);
    #1;
    cyc++;
    if (cyc == inc_cyc) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt == NW) m_done = 1;
    end
    check_outputs();
  endtask

  task automatic send(input int a, input bit d);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, a, d);
      if (last_acc) return;
    end
    chk("send_timeout", 32'(cfg_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'($urandom));
  endtask

  initial begin
    @(posedge prog_clk);
    #1;
    do_reset();

    // Single write of 7'b000_0010 = 1.
    send('b0000010, 1'b1);
    idle(5);

    // Back-to-back: valid held high across three words.
    send('h21, 1'b0);
    send('h35, 1'b1);
    send('h44, 1'b1);
    idle(5);

    // Random traffic until completion, then keep pushing valid.
    for (int i = 0; i < 1500 && m_done == 0; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 127), 1'($urandom));
    chk("completed", 32'(cfg_done), 32'd1);
    idle(4);
    for (int i = 0; i < 12; i++) step(1'b1, $urandom_range(0, 127), 1'($urandom));
    chk("final_count", 32'(wr_count), 32'(NW));

    // Illegal decoder field.
    do_reset();
    idle(1);
    send('b0001111, 1'b1);
    idle(6);
    send('h12, 1'b1);
    idle(5);

    // Reset asserted while the strobe is high.
    do_reset();
    send('h05, 1'b1);
    idle(4);
    send('h06, 1'b0);
    for (int i = 0; i < 10 && cyc != en_cyc; i++) idle(1);
    chk("strobe_seen", 32'(enable), 32'd1);
    do_reset();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
